gerenciador_alarme: RTL and testbench

GERENCIADOR_ALARME -- requirements
Module: gerenciador_alarme
Downstream consumer of the pressure monitor's 2-bit alerta code: persistence filter, alarm latch, acknowledge, blinking siren, event counter.

---
 rtl/gerenciador_alarme_pkg.sv | 26 ++
 rtl/gerenciador_alarme_pisca.sv | 47 ++++
 rtl/gerenciador_alarme.sv | 169 ++++++++++++++++
 tb/tb_gerenciador_alarme.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/gerenciador_alarme_pkg.sv
// ----------------------------------------------------------------------
// gerenciador_alarme_pkg: alerta codes, FSM encoding, helpers | Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package gerenciador_alarme_pkg;

  localparam logic [1:0] ALERTA_NORMAL = 2'b00;
  localparam logic [1:0] ALERTA_BAIXO  = 2'b01;
  localparam logic [1:0] ALERTA_ALTO   = 2'b10;
  localparam logic [1:0] ALERTA_FALHA  = 2'b11;

  typedef enum logic [1:0] {
    EST_NORMAL      = 2'd0,
    EST_SUSPEITA    = 2'd1,
    EST_ALARME      = 2'd2,
    EST_RECONHECIDO = 2'd3
  } estado_t;

  function automatic logic [7:0] incr_saturado(input logic [7:0] valor);
    return (valor == 8'hFF) ? valor : valor + 8'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gerenciador_alarme_pisca.sv
// ----------------------------------------------------------------------
// gerador_pisca: siren square wave, phase restarts high on habilita | Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module gerador_pisca
  import gerenciador_alarme_pkg::*;
#(
  parameter int PERIODO_PISCA = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic habilita,
  output logic pisca
);

  localparam int BW = $clog2(PERIODO_PISCA + 1);
  localparam logic [BW-1:0] B_MAX = BW'(PERIODO_PISCA);

  logic [BW-1:0] cont;
  logic          habilita_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pisca      <= 1'b0;
      cont       <= '0;
      habilita_d <= 1'b0;
    end else begin
      habilita_d <= habilita;
      if (!habilita) begin
        pisca <= 1'b0;
        cont  <= '0;
      end else if (!habilita_d) begin
        pisca <= 1'b1;
        cont  <= BW'(1);
      end else if (cont == B_MAX) begin
        pisca <= ~pisca;
        cont  <= BW'(1);
      end else begin
        cont  <= cont + BW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gerenciador_alarme.sv
// ----------------------------------------------------------------------
// gerenciador_alarme: persistence filter, alarm latch, ack, siren | Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module gerenciador_alarme
  import gerenciador_alarme_pkg::*;
#(
  parameter int PERSISTENCIA  = 4,
  parameter int PERIODO_PISCA = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] alerta,
  input  logic       reconhece,
  output logic       alarme_ativo,
  output logic [1:0] tipo,
  output logic       sirene,
  output logic [7:0] eventos
);

  localparam int CW = $clog2(PERSISTENCIA + 1);
  localparam logic [CW-1:0] P_MAX = CW'(PERSISTENCIA);

  estado_t       estado, estado_prox;
  logic [1:0]    candidato, candidato_prox;
  logic [CW-1:0] cont, cont_prox, cont_mais;
  logic [1:0]    tipo_prox;
  logic          conta_evento;
  logic          mesma;
  logic          codigo_nivel;
  logic          habilita;

  assign cont_mais    = cont + CW'(1);
  assign mesma        = (alerta == candidato) && (cont != '0);
  assign codigo_nivel = (alerta == ALERTA_BAIXO) || (alerta == ALERTA_ALTO);
  assign habilita     = (estado_prox == EST_ALARME);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado       <= EST_NORMAL;
      candidato    <= ALERTA_NORMAL;
      cont         <= '0;
      alarme_ativo <= 1'b0;
      tipo         <= ALERTA_NORMAL;
      eventos      <= 8'd0;
    end else begin
      estado       <= estado_prox;
      candidato    <= candidato_prox;
      cont         <= cont_prox;
      alarme_ativo <= (estado_prox == EST_ALARME) || (estado_prox == EST_RECONHECIDO);
      tipo         <= tipo_prox;
      if (conta_evento) eventos <= incr_saturado(eventos);
    end
  end

  always_comb begin
    estado_prox    = estado;
    candidato_prox = candidato;
    cont_prox      = cont;
    tipo_prox      = tipo;
    conta_evento   = 1'b0;
    unique case (estado)
      EST_NORMAL: begin
        if (alerta == ALERTA_FALHA) begin
          estado_prox  = EST_ALARME;
          tipo_prox    = ALERTA_FALHA;
          conta_evento = 1'b1;
          cont_prox    = '0;
        end else if (codigo_nivel) begin
          estado_prox    = EST_SUSPEITA;
          candidato_prox = alerta;
          cont_prox      = CW'(1);
        end
      end
      EST_SUSPEITA: begin
        if (alerta == ALERTA_FALHA) begin
          estado_prox  = EST_ALARME;
          tipo_prox    = ALERTA_FALHA;
          conta_evento = 1'b1;
          cont_prox    = '0;
        end else if (alerta == ALERTA_NORMAL) begin
          estado_prox    = EST_NORMAL;
          candidato_prox = ALERTA_NORMAL;
          cont_prox      = '0;
        end else if (alerta == candidato) begin
          if (cont_mais == P_MAX) begin
            estado_prox  = EST_ALARME;
            tipo_prox    = candidato;
            conta_evento = 1'b1;
            cont_prox    = '0;
          end else begin
            cont_prox = cont_mais;
          end
        end else begin
          candidato_prox = alerta;
          cont_prox      = CW'(1);
        end
      end
      EST_ALARME: begin
        // A different level code persisting only retypes the alarm; the siren keeps its phase.
        if ((alerta == ALERTA_FALHA) && (tipo != ALERTA_FALHA)) begin
          tipo_prox    = ALERTA_FALHA;
          conta_evento = 1'b1;
          cont_prox    = '0;
        end else if (reconhece) begin
          estado_prox = EST_RECONHECIDO;
          cont_prox   = '0;
        end else if (codigo_nivel && (alerta != tipo)) begin
          if (mesma) begin
            if (cont_mais == P_MAX) begin
              tipo_prox = alerta;
              cont_prox = '0;
            end else begin
              cont_prox = cont_mais;
            end
          end else begin
            candidato_prox = alerta;
            cont_prox      = CW'(1);
          end
        end else begin
          cont_prox = '0;
        end
      end
      EST_RECONHECIDO: begin
        // One counter serves both the clear run (00) and a new-code run.
        if (alerta == ALERTA_FALHA) begin
          estado_prox  = EST_ALARME;
          tipo_prox    = ALERTA_FALHA;
          conta_evento = 1'b1;
          cont_prox    = '0;
        end else if (alerta == tipo) begin
          cont_prox = '0;
        end else if (mesma) begin
          if (cont_mais == P_MAX) begin
            cont_prox = '0;
            if (alerta == ALERTA_NORMAL) begin
              estado_prox    = EST_NORMAL;
              tipo_prox      = ALERTA_NORMAL;
              candidato_prox = ALERTA_NORMAL;
            end else begin
              estado_prox  = EST_ALARME;
              tipo_prox    = alerta;
              conta_evento = 1'b1;
            end
          end else begin
            cont_prox = cont_mais;
          end
        end else begin
          candidato_prox = alerta;
          cont_prox      = CW'(1);
        end
      end
      default: estado_prox = EST_NORMAL;
    endcase
  end

  gerador_pisca #(
    .PERIODO_PISCA(PERIODO_PISCA)
  ) u_pisca (
    .clk     (clk),
    .rst     (rst),
    .habilita(habilita),
    .pisca   (sirene)
  );

endmodule

`default_nettype wire

// File: tb/tb_gerenciador_alarme.sv
// ----------------------------------------------------------------------
// tb_gerenciador_alarme: directed bench, PERSISTENCIA=4, PERIODO_PISCA=3 | Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_gerenciador_alarme;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alerta;
  logic       reconhece;
  logic       alarme_ativo;
  logic [1:0] tipo;
  logic       sirene;
  logic [7:0] eventos;

  int checks = 0;
  int errors = 0;

  gerenciador_alarme #(
    .PERSISTENCIA (4),
    .PERIODO_PISCA(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .alerta      (alerta),
    .reconhece   (reconhece),
    .alarme_ativo(alarme_ativo),
    .tipo        (tipo),
    .sirene      (sirene),
    .eventos     (eventos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [1:0] a, input logic r);
    alerta    = a;
    reconhece = r;
    @(posedge clk);
    #1;
    reconhece = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic at, input logic [1:0] tp,
                         input logic sr, input logic [7:0] ev);
    chk({tag, ".alarme"},  8'(alarme_ativo), 8'(at));
    chk({tag, ".tipo"},    8'(tipo),         8'(tp));
    chk({tag, ".sirene"},  8'(sirene),       8'(sr));
    chk({tag, ".eventos"}, eventos,          ev);
  endtask

  logic blink_exp [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    rst = 1'b1; alerta = 2'b00; reconhece = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 2'b00, 1'b0, 8'd0);
    rst = 1'b0;

    // 01 persisting four samples confirms on the fourth edge
    repeat (3) tick(2'b01, 1'b0);
    chk_all("persist3", 1'b0, 2'b00, 1'b0, 8'd0);
    tick(2'b01, 1'b0);
    chk_all("persist4", 1'b1, 2'b01, 1'b1, 8'd1);

    for (int i = 0; i < 6; i++) begin
      tick(2'b00, 1'b0);
      chk($sformatf("blink%0d", i), 8'(sirene), 8'(blink_exp[i]));
    end
    chk("latched", 8'(alarme_ativo), 8'd1);

    tick(2'b00, 1'b1);
    chk_all("ack", 1'b1, 2'b01, 1'b0, 8'd1);
    repeat (3) tick(2'b00, 1'b0);
    chk("clear3", 8'(alarme_ativo), 8'd1);
    tick(2'b00, 1'b0);
    chk_all("clear4", 1'b0, 2'b00, 1'b0, 8'd1);

    tick(2'b00, 1'b1);
    chk("ack_ignored", 8'(alarme_ativo), 8'd0);

    repeat (3) tick(2'b01, 1'b0);
    tick(2'b00, 1'b0);
    chk("short_run", 8'(alarme_ativo), 8'd0);
    repeat (3) tick(2'b01, 1'b0);
    chk("short_restart", 8'(alarme_ativo), 8'd0);
    tick(2'b00, 1'b0);

    // Candidate replacement: 10,10 then 01 x4
    tick(2'b10, 1'b0); tick(2'b10, 1'b0);
    repeat (3) tick(2'b01, 1'b0);
    chk("cand5", 8'(alarme_ativo), 8'd0);
    tick(2'b01, 1'b0);
    chk_all("cand6", 1'b1, 2'b01, 1'b1, 8'd2);
    tick(2'b00, 1'b1);
    repeat (4) tick(2'b00, 1'b0);
    chk("cand_clear", 8'(alarme_ativo), 8'd0);

    // Sensor fault bypasses persistence; repeats are ignored
    tick(2'b11, 1'b0);
    chk_all("falha", 1'b1, 2'b11, 1'b1, 8'd3);
    repeat (2) tick(2'b11, 1'b0);
    chk("falha_rep", eventos, 8'd3);

    // Different level code retypes the alarm without counting an event
    repeat (3) tick(2'b10, 1'b0);
    chk("retype3", 8'(tipo), 8'h3);
    tick(2'b10, 1'b0);
    chk("retype4", 8'(tipo), 8'h2);
    chk("retype_ev", eventos, 8'd3);

    tick(2'b00, 1'b1);
    repeat (4) tick(2'b10, 1'b0);
    chk_all("same_no_realarm", 1'b1, 2'b10, 1'b0, 8'd3);
    repeat (4) tick(2'b01, 1'b0);
    chk_all("new_realarm", 1'b1, 2'b01, 1'b1, 8'd4);
    tick(2'b00, 1'b1);
    repeat (4) tick(2'b00, 1'b0);
    chk("realarm_clear", 8'(alarme_ativo), 8'd0);

    // Asynchronous reset mid-blink
    tick(2'b11, 1'b0);
    repeat (2) tick(2'b00, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 2'b00, 1'b0, 8'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick(2'b01, 1'b0);
    chk("post_rst3", 8'(alarme_ativo), 8'd0);
    tick(2'b01, 1'b0);
    chk_all("post_rst4", 1'b1, 2'b01, 1'b1, 8'd1);
    tick(2'b00, 1'b1);
    repeat (4) tick(2'b00, 1'b0);

    // 256 more confirmed alarms: 1 + 256 saturates at 255
    for (int n = 0; n < 256; n++) begin
      tick(2'b11, 1'b0);
      tick(2'b00, 1'b1);
      repeat (4) tick(2'b00, 1'b0);
      if (n == 252) chk("sat_254", eventos, 8'd254);
    end
    chk("sat_255", eventos, 8'd255);
    chk("sat_idle", 8'(alarme_ativo), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
